// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared types and sizing helpers for the CNN pipeline stages
//
// Contents:
//   pool_mode_e  pooling operator selection (max or floor-average)
//   cnt_w()      bit width of a counter that must hold 0..n-1
package cnn_pkg;

   typedef enum logic {
      POOL_MAX = 1'b0,
      POOL_AVG = 1'b1
   } pool_mode_e;

   // Width of a counter that must hold 0..n-1; never less than one bit.
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pool_pair_op.sv
// rtl/pool_pair_op.sv - combinational two-operand pooling primitive
//
// Combines two signed operands into one result that is one bit wider, so
// a chain of these never truncates: max is sign-extended, sum keeps the carry.
// Ports:
//   a, b  signed operands, DATA_W_IN bits
//   y     signed max(a,b) or a+b, DATA_W_IN+1 bits
module pool_pair_op
   import cnn_pkg::*;
#(
   parameter int         DATA_W_IN = 16,
   parameter pool_mode_e MODE      = POOL_MAX
) (
   input  logic signed [DATA_W_IN-1:0] a,
   input  logic signed [DATA_W_IN-1:0] b,
   output logic signed [DATA_W_IN:0]   y
);

   logic signed [DATA_W_IN:0] a_x;
   logic signed [DATA_W_IN:0] b_x;

   assign a_x = {a[DATA_W_IN-1], a};
   assign b_x = {b[DATA_W_IN-1], b};

   always_comb begin
      if (MODE == POOL_AVG) begin
         y = a_x + b_x;
      end else begin
         y = (a_x > b_x) ? a_x : b_x;
      end
   end

endmodule

// File: rtl/pool2x2_stream.sv
// rtl/pool2x2_stream.sv - streaming 2x2 stride-2 pooling stage with backpressure
//
// Consumes a raster-order multi-channel feature map, one pixel of every
// channel per beat, and emits the pooled map with valid/ready flow control.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   pixel_in      CH signed samples of DATA_W bits
//   valid_in      beat offered; taken when valid_in && ready
//   ready         beat can be taken this cycle
//   pixel_out     CH signed pooled results, held while out_ready is low
//   valid_out     pixel_out holds an untaken result
//   out_ready     downstream takes pixel_out this cycle
//   frame_done    one-cycle pulse after the last beat of a frame is taken
module pool2x2_stream
   import cnn_pkg::*;
#(
   parameter int         CH     = 4,
   parameter int         DATA_W = 16,
   parameter int         IMG_W  = 28,
   parameter int         IMG_H  = 28,
   parameter pool_mode_e MODE   = POOL_MAX,
   parameter bit         RELU   = 1'b0
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [CH-1:0][DATA_W-1:0] pixel_in,
   input  logic                      valid_in,
   output logic                      ready,
   output logic [CH-1:0][DATA_W-1:0] pixel_out,
   output logic                      valid_out,
   input  logic                      out_ready,
   output logic                      frame_done
);

   localparam int HALF_W = IMG_W / 2;
   localparam int CW     = cnt_w(IMG_W);
   localparam int RW     = cnt_w(IMG_H);

   logic [CW-1:0]             col;
   logic [RW-1:0]             row;
   logic [CW-1:0]             half_col;
   logic                      accept;
   logic                      last_col;
   logic                      last_row;
   logic                      row_in_win;
   logic                      win_done;
   logic [CH-1:0][DATA_W-1:0] hold_reg;
   logic [DATA_W:0]           linebuf [CH][HALF_W];
   logic [CH-1:0][DATA_W:0]   h_pair;
   logic [CH-1:0][DATA_W-1:0] result;

   // A result slot that is empty or being drained can take a new result,
   // so a full slot plus out_ready still accepts without a bubble.
   assign ready    = !valid_out || out_ready;
   assign accept   = valid_in && ready;
   assign last_col = (col == CW'(IMG_W - 1));
   assign last_row = (row == RW'(IMG_H - 1));
   assign half_col = col >> 1;

   // Only an odd image height leaves a trailing row that pairs with nothing.
   // Odd columns/rows are always inside a window, so win_done needs no guard.
   assign row_in_win = (IMG_H % 2 == 0) || !last_row;
   assign win_done   = accept && col[0] && row[0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         col        <= '0;
         row        <= '0;
         frame_done <= 1'b0;
         valid_out  <= 1'b0;
         pixel_out  <= '0;
      end else begin
         frame_done <= accept && last_col && last_row;
         if (accept) begin
            if (last_col) begin
               col <= '0;
               row <= last_row ? '0 : row + RW'(1);
            end else begin
               col <= col + CW'(1);
            end
         end
         if (win_done) begin
            valid_out <= 1'b1;
            pixel_out <= result;
         end else if (out_ready) begin
            valid_out <= 1'b0;
         end
      end
   end

   // Window state carries no reset: every read is preceded by a write
   // within the same frame, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (accept && !col[0]) begin
         hold_reg <= pixel_in;
      end
      for (int c = 0; c < CH; c++) begin
         for (int j = 0; j < HALF_W; j++) begin
            if (accept && col[0] && !row[0] && row_in_win && half_col == CW'(j)) begin
               linebuf[c][j] <= h_pair[c];
            end
         end
      end
   end

   for (genvar c = 0; c < CH; c++) begin : g_ch
      logic signed [DATA_W:0]   lb_rd;
      logic signed [DATA_W+1:0] v_pair;
      logic signed [DATA_W+1:0] scaled;

      always_comb begin
         lb_rd = '0;
         for (int j = 0; j < HALF_W; j++) begin
            if (half_col == CW'(j)) begin
               lb_rd = linebuf[c][j];
            end
         end
      end

      pool_pair_op #(.DATA_W_IN(DATA_W), .MODE(MODE)) u_h_op (
         .a (hold_reg[c]),
         .b (pixel_in[c]),
         .y (h_pair[c])
      );

      pool_pair_op #(.DATA_W_IN(DATA_W + 1), .MODE(MODE)) u_v_op (
         .a (lb_rd),
         .b (h_pair[c]),
         .y (v_pair)
      );

      // Arithmetic shift of the full-width sum gives the floor average,
      // which always fits back into DATA_W bits.
      assign scaled    = (MODE == POOL_AVG) ? (v_pair >>> 2) : v_pair;
      assign result[c] = (RELU && scaled[DATA_W-1]) ? '0 : scaled[DATA_W-1:0];
   end

endmodule

// File: tb/tb_pool2x2_stream.sv
// tb/tb_pool2x2_stream.sv - self-checking bench for pool2x2_stream
module tb_pool2x2_stream;
   import cnn_pkg::*;

   localparam int N_CH = 2;
   localparam int DW   = 16;
   localparam int W    = 5;
   localparam int H    = 5;
   localparam int NPIX = W * H;

   typedef logic [N_CH-1:0][DW-1:0] beat_t;
   typedef logic [2:0][N_CH-1:0][DW-1:0] exp_t;

   logic  clk = 1'b0;
   logic  reset_n;
   beat_t pixel_in;
   logic  valid_in;
   logic  out_ready;

   beat_t pout [3];
   logic  rdy  [3];
   logic  vout [3];
   logic  fd   [3];

   // dut0: max, dut1: floor average, dut2: max with ReLU
   for (genvar k = 0; k < 3; k++) begin : g_dut
      pool2x2_stream #(
         .CH(N_CH), .DATA_W(DW), .IMG_W(W), .IMG_H(H),
         .MODE(k == 1 ? POOL_AVG : POOL_MAX), .RELU(k == 2)
      ) u_dut (
         .clk        (clk),
         .reset_n    (reset_n),
         .pixel_in   (pixel_in),
         .valid_in   (valid_in),
         .ready      (rdy[k]),
         .pixel_out  (pout[k]),
         .valid_out  (vout[k]),
         .out_ready  (out_ready),
         .frame_done (fd[k])
      );
   end

   always #5 clk = ~clk;

   int   n_chk = 0;
   int   n_err = 0;
   int   n_fd  = 0;
   int   hold_off = 0;
   int   bcnt = 0;
   bit   exp_fd = 1'b0;
   bit   acc_flag = 1'b0;
   int   pix [N_CH][H][W];
   exp_t expq [$];
   exp_t cap  [$];

   int lit1 [3][4][2] = '{
      '{'{6, 0},  '{8, -2}, '{16, -10}, '{18, -12}},
      '{'{3, -3}, '{5, -5}, '{13, -13}, '{15, -15}},
      '{'{6, 0},  '{8, 0},  '{16, 0},   '{18, 0}}
   };
   int lit2 [3][4][2] = '{
      '{'{-1, -5}, '{3, 0},  '{32767, -32768}, '{32767, -32767}},
      '{'{-3, -7}, '{-1, 0}, '{32767, -32768}, '{-1, -32768}},
      '{'{0, 0},   '{3, 0},  '{32767, 0},      '{32767, 0}}
   };

   task automatic chk(input string nm, input int k, input longint got, input longint want);
      n_chk++;
      if (got != want) begin
         n_err++;
         $display("FAIL %s dut%0d: got %0d required %0d", nm, k, got, want);
      end
   endtask

   // Pooled value of the window whose bottom-right pixel is (r,c).
   function automatic int win_val(input int k, input int ch, input int r, input int c);
      int v [4];
      int s;
      int q;
      v[0] = pix[ch][r-1][c-1];
      v[1] = pix[ch][r-1][c];
      v[2] = pix[ch][r][c-1];
      v[3] = pix[ch][r][c];
      if (k == 1) begin
         s = v[0] + v[1] + v[2] + v[3];
         q = s / 4;
         if (s < 0 && s % 4 != 0) q = q - 1;
      end else begin
         q = v[0];
         for (int i = 1; i < 4; i++) if (v[i] > q) q = v[i];
         if (k == 2 && q < 0) q = 0;
      end
      return q;
   endfunction

   // Compare process: checks every cycle, then advances the model to the next edge.
   always @(negedge clk) begin
      exp_t e;
      bit   acc;
      int   r;
      int   c;
      int   q;
      if (!reset_n) begin
         for (int k = 0; k < 3; k++) begin
            chk("rst_valid_out", k, vout[k], 0);
            chk("rst_frame_done", k, fd[k], 0);
            chk("rst_pixel_out", k, pout[k], 0);
            chk("rst_ready", k, rdy[k], 1);
         end
         expq.delete();
         cap.delete();
         bcnt     = 0;
         exp_fd   = 1'b0;
         acc_flag = 1'b0;
      end else begin
         for (int k = 0; k < 3; k++) begin
            chk("ready", k, rdy[k], (expq.size() == 0) || out_ready);
            chk("valid_out", k, vout[k], expq.size() != 0);
            chk("frame_done", k, fd[k], exp_fd);
            if (expq.size() != 0) chk("pixel_out", k, pout[k], expq[0][k]);
         end
         if (fd[0]) n_fd++;
         acc = valid_in && ((expq.size() == 0) || out_ready);
         if (expq.size() != 0 && out_ready) begin
            for (int k = 0; k < 3; k++) e[k] = pout[k];
            cap.push_back(e);
            void'(expq.pop_front());
         end
         exp_fd = 1'b0;
         if (acc) begin
            r = bcnt / W;
            c = bcnt % W;
            for (int ch = 0; ch < N_CH; ch++) pix[ch][r][c] = int'($signed(pixel_in[ch]));
            if (r % 2 == 1 && c % 2 == 1) begin
               for (int k = 0; k < 3; k++)
                  for (int ch = 0; ch < N_CH; ch++) begin
                     q = win_val(k, ch, r, c);
                     e[k][ch] = q[DW-1:0];
                  end
               expq.push_back(e);
            end
            if (bcnt == NPIX - 1) exp_fd = 1'b1;
            bcnt = (bcnt + 1) % NPIX;
         end
         acc_flag = acc;
      end
   end

   task automatic set_ready(input int stall_pct);
      if (hold_off > 0) begin
         out_ready = 1'b0;
         hold_off--;
      end else begin
         out_ready = ($urandom_range(99) >= stall_pct);
      end
   endtask

   task automatic send(input beat_t v, input int gap_pct, input int stall_pct);
      int budget;
      while ($urandom_range(99) < gap_pct) begin
         valid_in = 1'b0;
         set_ready(stall_pct);
         @(posedge clk); #1;
      end
      valid_in = 1'b1;
      pixel_in = v;
      budget   = 0;
      set_ready(stall_pct);
      @(posedge clk); #1;
      while (!acc_flag) begin
         budget++;
         if (budget > 200) begin
            n_chk++;
            n_err++;
            $display("FAIL accept_timeout: got no accept in %0d cycles required accept", budget);
            valid_in = 1'b0;
            return;
         end
         set_ready(stall_pct);
         @(posedge clk); #1;
      end
      valid_in = 1'b0;
   endtask

   task automatic drain();
      valid_in  = 1'b0;
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
   endtask

   function automatic int f2v(input int ch, input int r, input int c);
      if (r == 4 || c == 4) return (ch == 0) ? 999 : -999;
      if (r < 2 && c < 2)   return (ch == 0) ? -(1 + c + 2*r) : -(5 + c + 2*r);
      if (r < 2) begin
         if (ch == 1) return 0;
         case (c + 2*r)
            2:       return -1;
            3:       return 3;
            4:       return -2;
            default: return -4;
         endcase
      end
      if (c < 2)   return (ch == 0) ? 32767 : -32768;
      if (ch == 0) return (c == 2) ? 32767 : -32768;
      return (r == 3 && c == 3) ? -32767 : -32768;
   endfunction

   task automatic check_lit(input string nm, input int lit [3][4][2]);
      chk({nm, "_count"}, 0, cap.size(), 4);
      if (cap.size() == 4) begin
         for (int i = 0; i < 4; i++)
            for (int k = 0; k < 3; k++)
               for (int ch = 0; ch < N_CH; ch++)
                  chk(nm, k, int'($signed(cap[i][k][ch])), lit[k][i][ch]);
      end
   endtask

   initial begin
      beat_t v;
      int    t;
      reset_n   = 1'b0;
      valid_in  = 1'b0;
      out_ready = 1'b1;
      pixel_in  = '0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;

      // Frame 1: ch0 = raster index, ch1 = its negation, no gaps.
      cap.delete();
      n_fd = 0;
      for (int b = 0; b < NPIX; b++) begin
         t = b;
         v[0] = t[DW-1:0];
         t = -b;
         v[1] = t[DW-1:0];
         send(v, 0, 0);
      end
      drain();
      check_lit("frame1", lit1);
      chk("frame1_done_count", 0, n_fd, 1);

      // Frame 2: negative, mixed and full-scale windows; row/col 4 carry junk.
      cap.delete();
      for (int b = 0; b < NPIX; b++) begin
         for (int ch = 0; ch < N_CH; ch++) begin
            t = f2v(ch, b / W, b % W);
            v[ch] = t[DW-1:0];
         end
         send(v, 0, 0);
      end
      drain();
      check_lit("frame2", lit2);

      // Frame 3: downstream stalled for 10 cycles while beats keep coming.
      hold_off = 10;
      for (int b = 0; b < NPIX; b++) begin
         for (int ch = 0; ch < N_CH; ch++) v[ch] = DW'($urandom);
         send(v, 0, 0);
      end
      drain();

      // Random gaps and stalls, with a reset in the middle of the second frame.
      for (int f = 0; f < 7; f++) begin
         for (int b = 0; b < NPIX; b++) begin
            if (f == 1 && b == 12) begin
               reset_n = 1'b0;
               @(posedge clk); #1;
               reset_n = 1'b1;
               break;
            end
            for (int ch = 0; ch < N_CH; ch++) v[ch] = DW'($urandom);
            send(v, 30, 40);
         end
      end
      drain();
      chk("post_reset_outputs", 0, cap.size(), 5 * 4);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
